// File: rtl/window_control.sv
// SPARC V8 CWP/WIM/ET controller: register-file window select, window overflow/underflow and trap entry.
// Outputs are registered one edge after acceptance. op_ready is held low while a trap is pending or in error mode.
module window_control #(
    parameter int NWINDOWS = 4
) (
    input  logic                        Clk,
    input  logic                        Clr,
    input  logic                        op_valid,
    input  logic [2:0]                  op,
    input  logic [4:0]                  wdata,
    input  logic                        ext_trap,
    input  logic [7:0]                  ext_tt,
    input  logic                        trap_ack,
    output logic                        op_ready,
    output logic                        op_done,
    output logic [$clog2(NWINDOWS)-1:0] cwp,
    output logic [NWINDOWS-1:0]         wim,
    output logic                        et,
    output logic                        trap_req,
    output logic [7:0]                  trap_tt,
    output logic                        error
);
    localparam int CW = $clog2(NWINDOWS);

    localparam logic [2:0] OP_SAVE    = 3'b001;
    localparam logic [2:0] OP_RESTORE = 3'b010;
    localparam logic [2:0] OP_RETT    = 3'b011;
    localparam logic [2:0] OP_WRCWP   = 3'b100;
    localparam logic [2:0] OP_WRWIM   = 3'b101;
    localparam logic [2:0] OP_WRET    = 3'b110;

    localparam logic [7:0] TT_OVERFLOW  = 8'h05;
    localparam logic [7:0] TT_UNDERFLOW = 8'h06;
    localparam logic [7:0] TT_ILLEGAL   = 8'h02;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_PEND = 2'd1,
        ERROR     = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cwp_nxt, cwp_dec, cwp_inc;
    logic [NWINDOWS-1:0] wim_nxt;
    logic                et_nxt, req_nxt, done_nxt, err_nxt;
    logic [7:0]          tt_nxt;
    logic                raise;
    logic [7:0]          code;

    // Window arithmetic wraps naturally for a power-of-two window count.
    assign cwp_dec  = cwp - CW'(1);
    assign cwp_inc  = cwp + CW'(1);
    assign op_ready = (state == IDLE) && (!ext_trap || !et);

    always_comb begin
        state_nxt = state;
        cwp_nxt   = cwp;
        wim_nxt   = wim;
        et_nxt    = et;
        req_nxt   = trap_req;
        tt_nxt    = trap_tt;
        done_nxt  = 1'b0;
        err_nxt   = error;
        raise     = 1'b0;
        code      = 8'h00;

        case (state)
            IDLE: begin
                if (ext_trap && et) begin
                    raise = 1'b1;
                    code  = ext_tt;
                end else if (op_valid) begin
                    case (op)
                        OP_SAVE: begin
                            if (wim[cwp_dec]) begin
                                raise = 1'b1;
                                code  = TT_OVERFLOW;
                            end else begin
                                cwp_nxt = cwp_dec;
                            end
                        end
                        OP_RESTORE: begin
                            if (wim[cwp_inc]) begin
                                raise = 1'b1;
                                code  = TT_UNDERFLOW;
                            end else begin
                                cwp_nxt = cwp_inc;
                            end
                        end
                        OP_RETT: begin
                            if (et) begin
                                raise = 1'b1;
                                code  = TT_ILLEGAL;
                            end else if (wim[cwp_inc]) begin
                                raise = 1'b1;
                                code  = TT_UNDERFLOW;
                            end else begin
                                cwp_nxt = cwp_inc;
                                et_nxt  = 1'b1;
                            end
                        end
                        OP_WRCWP: begin
                            if (wdata >= 5'(NWINDOWS)) begin
                                raise = 1'b1;
                                code  = TT_ILLEGAL;
                            end else begin
                                cwp_nxt = wdata[CW-1:0];
                            end
                        end
                        OP_WRWIM: wim_nxt = wdata[NWINDOWS-1:0];
                        OP_WRET:  et_nxt  = wdata[0];
                        default:  ;
                    endcase
                    done_nxt = !raise;
                end

                // A trap with traps disabled is fatal until reset.
                if (raise) begin
                    if (et) begin
                        state_nxt = TRAP_PEND;
                        req_nxt   = 1'b1;
                        tt_nxt    = code;
                    end else begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            TRAP_PEND: begin
                if (trap_ack) begin
                    cwp_nxt   = cwp_dec;
                    et_nxt    = 1'b0;
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            ERROR:   ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state    <= IDLE;
            cwp      <= '0;
            wim      <= '0;
            et       <= 1'b0;
            trap_req <= 1'b0;
            trap_tt  <= 8'h00;
            op_done  <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cwp      <= cwp_nxt;
            wim      <= wim_nxt;
            et       <= et_nxt;
            trap_req <= req_nxt;
            trap_tt  <= tt_nxt;
            op_done  <= done_nxt;
            error    <= err_nxt;
        end
    end
endmodule

// File: tb/tb_window_control.sv
// Directed test-plan sequence followed by random traffic, checked against an arithmetic model of the window rules.
module tb_window_control;
    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic [4:0] wdata = 5'd0;
    logic       ext_trap = 1'b0;
    logic [7:0] ext_tt = 8'h00;
    logic       trap_ack = 1'b0;
    logic       op_ready, op_done, et, trap_req, error;
    logic [1:0] cwp;
    logic [3:0] wim;
    logic [7:0] trap_tt;

    int checks = 0;
    int failures = 0;

    // Model state: 0 idle, 1 trap pending, 2 error.
    int m_state = 0, m_cwp = 0, m_wim = 0, m_et = 0;
    int m_req = 0, m_tt = 0, m_done = 0, m_err = 0;

    window_control #(.NWINDOWS(4)) dut (
        .Clk(Clk), .Clr(Clr), .op_valid(op_valid), .op(op), .wdata(wdata),
        .ext_trap(ext_trap), .ext_tt(ext_tt), .trap_ack(trap_ack),
        .op_ready(op_ready), .op_done(op_done), .cwp(cwp), .wim(wim), .et(et),
        .trap_req(trap_req), .trap_tt(trap_tt), .error(error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit clr, input bit vld, input int o, input int wd,
                                input bit ext, input int tt, input bit ack);
        bit trap;
        int code, dec, inc;
        trap = 0;
        code = 0;
        m_done = 0;
        if (clr) begin
            m_state = 0; m_cwp = 0; m_wim = 0; m_et = 0;
            m_req = 0; m_tt = 0; m_err = 0;
        end else if (m_state == 0) begin
            dec = (m_cwp + 3) % 4;
            inc = (m_cwp + 1) % 4;
            if (ext && m_et != 0) begin
                trap = 1; code = tt;
            end else if (vld) begin
                case (o)
                    1: if (((m_wim >> dec) & 1) != 0) begin trap = 1; code = 5; end else m_cwp = dec;
                    2: if (((m_wim >> inc) & 1) != 0) begin trap = 1; code = 6; end else m_cwp = inc;
                    3: if (m_et != 0) begin trap = 1; code = 2; end
                       else if (((m_wim >> inc) & 1) != 0) begin trap = 1; code = 6; end
                       else begin m_cwp = inc; m_et = 1; end
                    4: if (wd >= 4) begin trap = 1; code = 2; end else m_cwp = wd;
                    5: m_wim = wd % 16;
                    6: m_et = wd % 2;
                    default: ;
                endcase
                if (!trap) m_done = 1;
            end
            if (trap) begin
                if (m_et != 0) begin m_state = 1; m_req = 1; m_tt = code; end
                else begin m_state = 2; m_err = 1; end
            end
        end else if (m_state == 1 && ack) begin
            m_cwp = (m_cwp + 3) % 4;
            m_et = 0; m_req = 0; m_state = 0;
        end
    endtask

    // Called just after a falling edge: drive, check op_ready, clock, compare registered outputs.
    task automatic step(input bit clr, input bit vld, input logic [2:0] o, input logic [4:0] wd,
                        input bit ext, input logic [7:0] tt, input bit ack);
        bit rdy;
        Clr = clr; op_valid = vld; op = o; wdata = wd;
        ext_trap = ext; ext_tt = tt; trap_ack = ack;
        #1;
        rdy = (m_state == 0) && !(ext && m_et != 0);
        chk("op_ready", 8'(op_ready), 8'(rdy));
        model_update(clr, vld, int'(o), int'(wd), ext, int'(tt), ack);
        @(posedge Clk);
        @(negedge Clk);
        chk("cwp", 8'(cwp), 8'(m_cwp));
        chk("wim", 8'(wim), 8'(m_wim));
        chk("et", 8'(et), 8'(m_et));
        chk("trap_req", 8'(trap_req), 8'(m_req));
        chk("trap_tt", trap_tt, 8'(m_tt));
        chk("op_done", 8'(op_done), 8'(m_done));
        chk("error", 8'(error), 8'(m_err));
    endtask

    task automatic do_op(input logic [2:0] o, input logic [4:0] wd);
        step(0, 1, o, wd, 0, 8'h00, 0);
    endtask

    task automatic idle_cycle();
        step(0, 0, 3'd0, 5'd0, 0, 8'h00, 0);
    endtask

    task automatic ack_cycle();
        step(0, 0, 3'd0, 5'd0, 0, 8'h00, 1);
    endtask

    task automatic reset_cycle();
        step(1, 0, 3'd0, 5'd0, 0, 8'h00, 0);
    endtask

    initial begin
        bit clr, vld, ext, ack;
        @(negedge Clk);
        reset_cycle();
        reset_cycle();
        chk("rst_cwp", 8'(cwp), 8'h0);
        chk("rst_wim", 8'(wim), 8'h0);
        chk("rst_trap_req", 8'(trap_req), 8'h0);

        // Basic SAVE/RESTORE: 0 -> 3 -> 2 -> 3
        do_op(3'b110, 5'd1);
        do_op(3'b101, 5'b00001);
        do_op(3'b001, 5'd0);
        chk("basic_save1", 8'(cwp), 8'h3);
        do_op(3'b001, 5'd0);
        chk("basic_save2", 8'(cwp), 8'h2);
        do_op(3'b010, 5'd0);
        chk("basic_restore", 8'(cwp), 8'h3);

        // Overflow with a delayed acknowledge
        do_op(3'b101, 5'b00100);
        do_op(3'b001, 5'd0);
        chk("ovf_tt", trap_tt, 8'h05);
        chk("ovf_cwp_hold", 8'(cwp), 8'h3);
        repeat (3) idle_cycle();
        chk("ovf_still_pending", 8'(trap_req), 8'h1);
        ack_cycle();
        chk("ovf_ack_cwp", 8'(cwp), 8'h2);
        chk("ovf_ack_et", 8'(et), 8'h0);

        // Underflow wrapping 3 -> 0
        do_op(3'b110, 5'd1);
        do_op(3'b100, 5'd3);
        do_op(3'b101, 5'b00001);
        do_op(3'b010, 5'd0);
        chk("unf_tt", trap_tt, 8'h06);
        chk("unf_no_done", 8'(op_done), 8'h0);
        ack_cycle();

        // RETT cases, then a trap with traps disabled
        do_op(3'b101, 5'd0);
        do_op(3'b100, 5'd2);
        do_op(3'b011, 5'd0);
        chk("rett_cwp", 8'(cwp), 8'h3);
        chk("rett_et", 8'(et), 8'h1);
        do_op(3'b011, 5'd0);
        chk("rett_twice_tt", trap_tt, 8'h02);
        ack_cycle();
        do_op(3'b101, 5'b00010);
        do_op(3'b001, 5'd0);
        chk("err_flag", 8'(error), 8'h1);
        do_op(3'b110, 5'd1);
        do_op(3'b001, 5'd0);
        reset_cycle();

        // WRCWP range check and external trap priority
        do_op(3'b110, 5'd1);
        do_op(3'b100, 5'd5);
        chk("wrcwp_tt", trap_tt, 8'h02);
        ack_cycle();
        do_op(3'b110, 5'd1);
        do_op(3'b100, 5'd3);
        chk("wrcwp_cwp", 8'(cwp), 8'h3);
        step(0, 1, 3'b001, 5'd0, 1, 8'h11, 0);
        chk("ext_tt", trap_tt, 8'h11);
        chk("ext_cwp_hold", 8'(cwp), 8'h3);

        // Reset while a trap is pending
        idle_cycle();
        reset_cycle();
        chk("clr_pend_req", 8'(trap_req), 8'h0);
        chk("clr_pend_cwp", 8'(cwp), 8'h0);
        idle_cycle();

        for (int i = 0; i < 800; i++) begin
            clr = (m_state == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 149) == 0);
            vld = ($urandom_range(0, 3) != 0);
            ext = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 2) == 0);
            step(clr, vld, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                 ext, 8'($urandom_range(0, 255)), ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
